// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the decoder, the ID/EX stage and the ALU.
// Holds the datapath widths and the ALU control encodings so that every
// pipeline block agrees on them.
// Contents:
//   DATA_W      operand / forwarded data width
//   REG_W       register-address width
//   CTRL_W      ALU control field width
//   alu_ctrl_e  ALU operation encodings (add, sub, set-less-than)
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int CTRL_W = 4;

    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_ctrl_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding selector for one ALU source.
// Picks the newest in-flight value for a register: EX/MEM beats MEM/WB, and
// register 0 is never forwarded because it always reads as the file value.
// Ports:
//   reg_addr         register address held in ID/EX
//   reg_data         register-file value captured in ID/EX
//   exmem_reg_write  EX/MEM writeback valid
//   exmem_rd         EX/MEM destination
//   exmem_result     EX/MEM value
//   memwb_reg_write  MEM/WB writeback valid
//   memwb_rd         MEM/WB destination
//   memwb_data       MEM/WB value
//   fwd_data         selected operand
module fwd_mux #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_W  = cpu_pkg::REG_W
) (
    input  logic [REG_W-1:0]  reg_addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] fwd_data
);

    logic addr_nonzero;
    logic hit_exmem;
    logic hit_memwb;

    assign addr_nonzero = (reg_addr != '0);
    assign hit_exmem    = exmem_reg_write && (exmem_rd == reg_addr) && addr_nonzero;
    assign hit_memwb    = memwb_reg_write && (memwb_rd == reg_addr) && addr_nonzero;

    // EX/MEM is checked first because it holds the younger result.
    always_comb begin
        fwd_data = reg_data;
        if (hit_exmem) begin
            fwd_data = exmem_result;
        end else if (hit_memwb) begin
            fwd_data = memwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, operand forwarding and
// a saturating back-pressure counter.
// Ports:
//   clk_i, rst_i                    clock, async active-high reset
//   in_valid / in_ready             decode-side handshake
//   RsData, RtData, Imm             operands from decode
//   ALUSrc                          1 = Imm drives Source2
//   ALU_Ctrl_in, Rs_in, Rt_in, Rd_in, RegWrite_in   decoded control
//   flush                           squash held and incoming instruction
//   exmem_*, memwb_*                forwarding sources
//   out_ready / out_valid           ALU-side handshake
//   Source1, Source2, ALU_Ctrl, Rd_out, RegWrite_out  to the ALU stage
//   stall_cnt                       cycles spent blocked by the ALU stage
module id_ex_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int CTRL_W = cpu_pkg::CTRL_W,
    parameter int REG_W  = cpu_pkg::REG_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] RsData,
    input  logic [DATA_W-1:0] RtData,
    input  logic [DATA_W-1:0] Imm,
    input  logic              ALUSrc,
    input  logic [CTRL_W-1:0] ALU_Ctrl_in,
    input  logic [REG_W-1:0]  Rs_in,
    input  logic [REG_W-1:0]  Rt_in,
    input  logic [REG_W-1:0]  Rd_in,
    input  logic              RegWrite_in,
    input  logic              flush,
    input  logic              exmem_RegWrite,
    input  logic [REG_W-1:0]  exmem_Rd,
    input  logic [DATA_W-1:0] exmem_Result,
    input  logic              memwb_RegWrite,
    input  logic [REG_W-1:0]  memwb_Rd,
    input  logic [DATA_W-1:0] memwb_Data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] Source1,
    output logic [DATA_W-1:0] Source2,
    output logic [CTRL_W-1:0] ALU_Ctrl,
    output logic [REG_W-1:0]  Rd_out,
    output logic              RegWrite_out,
    output logic [15:0]       stall_cnt
);

    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic              alu_src_q;
    logic [CTRL_W-1:0] alu_ctrl_q;
    logic [REG_W-1:0]  rs_q;
    logic [REG_W-1:0]  rt_q;
    logic [REG_W-1:0]  rd_q;
    logic              reg_write_q;
    logic              load;
    logic [DATA_W-1:0] rt_fwd;

    // The slot is free when empty or draining this cycle; flush blocks loads.
    assign in_ready = (!out_valid || out_ready) && !flush;
    assign load     = in_valid && in_ready;

    // Data fields only move on a load, so they hold while the ALU stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
            alu_ctrl_q  <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else if (load) begin
            rs_data_q   <= RsData;
            rt_data_q   <= RtData;
            imm_q       <= Imm;
            alu_src_q   <= ALUSrc;
            alu_ctrl_q  <= ALU_Ctrl_in;
            rs_q        <= Rs_in;
            rt_q        <= Rt_in;
            rd_q        <= Rd_in;
            reg_write_q <= RegWrite_in;
        end
    end

    // Valid bit: flush wins, a load refills (no bubble), a drain empties.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Back-pressure counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
        .reg_addr        (rs_q),
        .reg_data        (rs_data_q),
        .exmem_reg_write (exmem_RegWrite),
        .exmem_rd        (exmem_Rd),
        .exmem_result    (exmem_Result),
        .memwb_reg_write (memwb_RegWrite),
        .memwb_rd        (memwb_Rd),
        .memwb_data      (memwb_Data),
        .fwd_data        (Source1)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
        .reg_addr        (rt_q),
        .reg_data        (rt_data_q),
        .exmem_reg_write (exmem_RegWrite),
        .exmem_rd        (exmem_Rd),
        .exmem_result    (exmem_Result),
        .memwb_reg_write (memwb_RegWrite),
        .memwb_rd        (memwb_Rd),
        .memwb_data      (memwb_Data),
        .fwd_data        (rt_fwd)
    );

    assign Source2      = alu_src_q ? imm_q : rt_fwd;
    assign ALU_Ctrl     = alu_ctrl_q;
    assign Rd_out       = rd_q;
    assign RegWrite_out = reg_write_q && out_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: handshake, forwarding
// priority, register-0 rule, stall hold/count, flush, async reset and
// counter saturation.
module tb_id_ex_stage;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 4;
    localparam int REG_W  = 3;

    logic              clk_i;
    logic              rst_i;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] RsData;
    logic [DATA_W-1:0] RtData;
    logic [DATA_W-1:0] Imm;
    logic              ALUSrc;
    logic [CTRL_W-1:0] ALU_Ctrl_in;
    logic [REG_W-1:0]  Rs_in;
    logic [REG_W-1:0]  Rt_in;
    logic [REG_W-1:0]  Rd_in;
    logic              RegWrite_in;
    logic              flush;
    logic              exmem_RegWrite;
    logic [REG_W-1:0]  exmem_Rd;
    logic [DATA_W-1:0] exmem_Result;
    logic              memwb_RegWrite;
    logic [REG_W-1:0]  memwb_Rd;
    logic [DATA_W-1:0] memwb_Data;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] Source1;
    logic [DATA_W-1:0] Source2;
    logic [CTRL_W-1:0] ALU_Ctrl;
    logic [REG_W-1:0]  Rd_out;
    logic              RegWrite_out;
    logic [15:0]       stall_cnt;

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .REG_W(REG_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .RsData         (RsData),
        .RtData         (RtData),
        .Imm            (Imm),
        .ALUSrc         (ALUSrc),
        .ALU_Ctrl_in    (ALU_Ctrl_in),
        .Rs_in          (Rs_in),
        .Rt_in          (Rt_in),
        .Rd_in          (Rd_in),
        .RegWrite_in    (RegWrite_in),
        .flush          (flush),
        .exmem_RegWrite (exmem_RegWrite),
        .exmem_Rd       (exmem_Rd),
        .exmem_Result   (exmem_Result),
        .memwb_RegWrite (memwb_RegWrite),
        .memwb_Rd       (memwb_Rd),
        .memwb_Data     (memwb_Data),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .Source1        (Source1),
        .Source2        (Source2),
        .ALU_Ctrl       (ALU_Ctrl),
        .Rd_out         (Rd_out),
        .RegWrite_out   (RegWrite_out),
        .stall_cnt      (stall_cnt)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Drive the decode-side instruction fields and the ALU-side ready.
    task automatic applyStimulus(input logic vld, input logic [15:0] rs_d,
                                 input logic [15:0] rt_d, input logic [15:0] imm_v,
                                 input logic src, input logic [3:0] ctrl,
                                 input logic [2:0] rs, input logic [2:0] rt,
                                 input logic [2:0] rd, input logic rw,
                                 input logic rdy);
        in_valid    = vld;
        RsData      = rs_d;
        RtData      = rt_d;
        Imm         = imm_v;
        ALUSrc      = src;
        ALU_Ctrl_in = ctrl;
        Rs_in       = rs;
        Rt_in       = rt;
        Rd_in       = rd;
        RegWrite_in = rw;
        out_ready   = rdy;
    endtask

    task automatic setFwd(input logic ew, input logic [2:0] erd, input logic [15:0] eres,
                          input logic mw, input logic [2:0] mrd, input logic [15:0] mdat);
        exmem_RegWrite = ew;
        exmem_Rd       = erd;
        exmem_Result   = eres;
        memwb_RegWrite = mw;
        memwb_Rd       = mrd;
        memwb_Data     = mdat;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock edge, then settle to the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1;
        flush = 1'b0;
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        setFwd(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        @(negedge clk_i);
        @(negedge clk_i);

        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_stall_cnt", stall_cnt, 16'h0);
        checkOutput("reset_in_ready", in_ready, 1'b1);
        checkOutput("reset_regwrite_out", RegWrite_out, 1'b0);
        checkOutput("reset_source1", Source1, 16'h0);

        // First load on the first edge after reset release.
        rst_i = 1'b0;
        applyStimulus(1'b1, 16'd5, 16'd3, 16'h0, 1'b0, 4'b0010, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1);
        step();
        checkOutput("load1_out_valid", out_valid, 1'b1);
        checkOutput("load1_source1", Source1, 16'd5);
        checkOutput("load1_source2", Source2, 16'd3);
        checkOutput("load1_alu_ctrl", ALU_Ctrl, 4'b0010);
        checkOutput("load1_rd_out", Rd_out, 3'd3);
        checkOutput("load1_regwrite_out", RegWrite_out, 1'b1);

        // Back-to-back load with immediate operand.
        applyStimulus(1'b1, 16'd7, 16'd9, 16'h0100, 1'b1, 4'b0110, 3'd2, 3'd0, 3'd4, 1'b0, 1'b1);
        #1;
        checkOutput("b2b_in_ready", in_ready, 1'b1);
        step();
        checkOutput("b2b_out_valid", out_valid, 1'b1);
        checkOutput("b2b_source1", Source1, 16'd7);
        checkOutput("b2b_source2_imm", Source2, 16'h0100);
        checkOutput("b2b_alu_ctrl", ALU_Ctrl, 4'b0110);
        checkOutput("b2b_regwrite_out", RegWrite_out, 1'b0);

        // Forwarding on held Rs_q=2, purely combinational.
        in_valid  = 1'b0;
        out_ready = 1'b0;
        setFwd(1'b1, 3'd2, 16'h00AA, 1'b1, 3'd2, 16'h0055);
        #1;
        checkOutput("fwd_exmem_priority", Source1, 16'h00AA);
        exmem_RegWrite = 1'b0;
        #1;
        checkOutput("fwd_memwb", Source1, 16'h0055);
        exmem_RegWrite = 1'b1;
        exmem_Rd       = 3'd3;
        #1;
        checkOutput("fwd_exmem_rd_mismatch", Source1, 16'h0055);
        memwb_Rd = 3'd5;
        #1;
        checkOutput("fwd_none", Source1, 16'd7);
        setFwd(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);

        // Load Rs=0, Rt=1 then check register-0 rule and Rt forwarding.
        applyStimulus(1'b1, 16'h0, 16'h1234, 16'hDEAD, 1'b0, 4'b0111, 3'd0, 3'd1, 3'd1, 1'b1, 1'b1);
        @(negedge clk_i);
        step();
        checkOutput("r0_load_valid", out_valid, 1'b1);
        checkOutput("r0_source2_plain", Source2, 16'h1234);
        setFwd(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd1, 16'hBEEF);
        #1;
        checkOutput("r0_no_forward", Source1, 16'h0);
        checkOutput("rt_fwd_memwb", Source2, 16'hBEEF);
        setFwd(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        #1;
        checkOutput("rt_fwd_cleared", Source2, 16'h1234);

        // Stall three cycles while decode offers a new instruction.
        applyStimulus(1'b1, 16'h7777, 16'h1111, 16'h2222, 1'b1, 4'b0010, 3'd3, 3'd4, 3'd6, 1'b0, 1'b0);
        #1;
        checkOutput("stall_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("stall_out_valid", out_valid, 1'b1);
            checkOutput("stall_source1_hold", Source1, 16'h0);
            checkOutput("stall_source2_hold", Source2, 16'h1234);
            checkOutput("stall_alu_ctrl_hold", ALU_Ctrl, 4'b0111);
            checkOutput("stall_rd_hold", Rd_out, 3'd1);
        end
        checkOutput("stall_cnt_3", stall_cnt, 16'd3);

        // Flush with a held instruction and an incoming one.
        flush = 1'b1;
        #1;
        checkOutput("flush_in_ready", in_ready, 1'b0);
        step();
        checkOutput("flush_out_valid", out_valid, 1'b0);
        checkOutput("flush_regwrite_out", RegWrite_out, 1'b0);
        checkOutput("flush_stall_cnt", stall_cnt, 16'd3);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        checkOutput("flush_no_load", out_valid, 1'b0);

        // Reset pulsed between edges during a stall.
        applyStimulus(1'b1, 16'h4444, 16'h5555, 16'h0, 1'b0, 4'b0010, 3'd5, 3'd6, 3'd7, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        checkOutput("pre_reset_stall_cnt", stall_cnt, 16'd4);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("async_reset_out_valid", out_valid, 1'b0);
        checkOutput("async_reset_stall_cnt", stall_cnt, 16'd0);
        checkOutput("async_reset_source1", Source1, 16'd0);
        checkOutput("async_reset_regwrite", RegWrite_out, 1'b0);
        #1;
        rst_i = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("post_reset_no_beat", out_valid, 1'b0);

        // Load right after reset, then stall long enough to saturate.
        applyStimulus(1'b1, 16'h0042, 16'h0001, 16'h0, 1'b0, 4'b0010, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1);
        step();
        checkOutput("post_reset_load", out_valid, 1'b1);
        checkOutput("post_reset_source1", Source1, 16'h0042);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk_i);
        end
        @(negedge clk_i);
        checkOutput("sat_reach", stall_cnt, 16'hFFFF);
        step();
        step();
        checkOutput("sat_hold", stall_cnt, 16'hFFFF);
        checkOutput("sat_out_valid", out_valid, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, width of operands and forwarded data.
REQ-002 The block SHALL have parameter CTRL_W, default 4, width of ALU_Ctrl (0010 add, 0110 sub, 0111 slt).
REQ-003 The block SHALL have parameter REG_W, default 3, register-address width.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset: clk_i input 1 (rising-edge clock), then rst_i input 1 (asynchronous, active-high reset).
REQ-005 The block SHALL have these ports:
- in_valid input 1: decode offers an instruction
- in_ready output 1: stage can accept
- RsData input DATA_W: register-file read 1
- RtData input DATA_W: register-file read 2
- Imm input DATA_W: sign-extended immediate
- ALUSrc input 1: 1 selects Imm as Source2
- ALU_Ctrl_in input CTRL_W: decoded ALU operation
- Rs_in input REG_W: source 1 register address
- Rt_in input REG_W: source 2 register address
- Rd_in input REG_W: destination register address
- RegWrite_in input 1: instruction writes back
- flush input 1: squash held and incoming instruction
- exmem_RegWrite input 1: EX/MEM writeback valid
- exmem_Rd input REG_W: EX/MEM destination
- exmem_Result input DATA_W: EX/MEM forwarded value
- memwb_RegWrite input 1: MEM/WB writeback valid
- memwb_Rd input REG_W: MEM/WB destination
- memwb_Data input DATA_W: MEM/WB forwarded value
- out_ready input 1: ALU stage accepts
- out_valid output 1: Source1/Source2/ALU_Ctrl valid
- Source1 output DATA_W: forwarded ALU operand 1
- Source2 output DATA_W: forwarded/immediate ALU operand 2
- ALU_Ctrl output CTRL_W: registered operation
- Rd_out output REG_W: registered destination
- RegWrite_out output 1: registered RegWrite, gated by out_valid
- stall_cnt output 16: saturating back-pressure cycle count

Function
REQ-006 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-007 A load SHALL occur on a rising edge when in_valid && in_ready; it registers RsData, RtData, Imm, ALUSrc, ALU_Ctrl_in, Rs_in, Rt_in, Rd_in and RegWrite_in, and sets out_valid.
REQ-008 Latency SHALL be one cycle from load to out_valid.
REQ-009 While out_valid && !out_ready, all registered fields SHALL hold unchanged.
REQ-010 out_valid SHALL clear when out_ready is high and no load occurs.
REQ-011 flush SHALL clear out_valid on the next edge and block any load that cycle; registered data fields MAY remain stale.
REQ-012 Operand 1 forwarding SHALL be combinational:
- Source1 = exmem_Result if exmem_RegWrite && exmem_Rd==Rs_q && Rs_q!=0
- else memwb_Data if memwb_RegWrite && memwb_Rd==Rs_q && Rs_q!=0
- else RsData_q.
REQ-013 Operand 2 SHALL be forwarded by the same rule using Rt_q; Source2 SHALL then be Imm_q when ALUSrc_q=1, otherwise the forwarded Rt value.
REQ-014 EX/MEM SHALL take priority over MEM/WB when both match.
REQ-015 Register 0 SHALL never be forwarded.
REQ-016 RegWrite_out SHALL be RegWrite_q && out_valid.
REQ-017 stall_cnt SHALL increment each cycle out_valid && !out_ready && !flush, and SHALL saturate at 16'hFFFF without wrap.
REQ-018 Simultaneous out_ready and in_valid with out_valid=1 SHALL load the new instruction and keep out_valid=1 (back-to-back, no bubble).

Reset
REQ-019 rst_i SHALL asynchronously clear out_valid, stall_cnt, all registered data/control fields (to 0) and RegWrite_q.
REQ-020 An instruction in flight when rst_i asserts SHALL be discarded with no output beat.
REQ-021 The first load SHALL be possible on the first edge after rst_i deasserts.

Structure
REQ-022 ALU_Ctrl encodings (ADD=4'b0010, SUB=4'b0110, SLT=4'b0111) and DATA_W/REG_W SHALL reside in a shared cpu package, also used by the ALU and decoder.
REQ-023 Forwarding selection SHALL be one sub-module, fwd_mux, instantiated twice (Rs and Rt).

Verification
REQ-024 Load Rs=1 (RsData=5), Rt=2 (RtData=3), ALU_Ctrl=0010, out_ready=1 -> next cycle out_valid=1, Source1=5, Source2=3.
REQ-025 Held Rs_q=2 with exmem (RegWrite=1, Rd=2, Result=0x00AA) and memwb (RegWrite=1, Rd=2, Data=0x0055) -> Source1=0x00AA; drop exmem_RegWrite -> Source1=0x0055.
REQ-026 Rs_q=0 with exmem_Rd=0, exmem_RegWrite=1, Result=0xFFFF -> Source1=RsData_q (0), no forward.
REQ-027 out_ready=0 for 3 cycles with out_valid=1 and new in_valid -> in_ready=0, outputs stable, stall_cnt=3.
REQ-028 flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, RegWrite_out=0, no load.
REQ-029 rst_i pulsed mid-stall between clock edges -> out_valid=0 and stall_cnt=0 immediately, before the next clock edge.
